// File: rtl/input_link_buffer_pkg.sv
// input_link_pkg: shared state type, channel packing and width helpers for the input link buffer
package input_link_pkg;
  typedef enum logic [1:0] {IDLE, ACCEPT, DRAIN} state_t;
  localparam int PACK_MAX = 1024;
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction
  function automatic logic [PACK_MAX-1:0] pack_word(input logic [PACK_MAX-1:0] din, input int nch,
                                                    input int in_w, input int keep);
    logic [PACK_MAX-1:0] r;
    r = '0;
    for (int c = 0; c < nch; c++)
      for (int b = 0; b < keep; b++)
        r[c*keep+b] = din[c*in_w+in_w-keep+b];
    return r;
  endfunction
endpackage

// File: rtl/input_link_buffer_if.sv
// input_link_buffer_if: link-side and reader-side handshake bundle of the input link buffer
interface input_link_buffer_if #(
  parameter int NCH   = 2,
  parameter int IN_W  = 32,
  parameter int KEEP  = 18,
  parameter int OVF_W = 16
);
  logic                 en_proc;
  logic                 start;
  logic                 done;
  logic [NCH*IN_W-1:0]  data_in;
  logic                 in_valid;
  logic                 read_en;
  logic                 empty;
  logic                 full;
  logic [NCH*KEEP-1:0]  data_out;
  logic                 out_valid;
  logic [OVF_W-1:0]     ovf_count;
  modport slave (input en_proc, start, data_in, in_valid, read_en,
                 output done, empty, full, data_out, out_valid, ovf_count);
  modport master (output en_proc, start, data_in, in_valid, read_en,
                  input done, empty, full, data_out, out_valid, ovf_count);
endinterface

// File: rtl/input_link_buffer_fifo.sv
// sync_fifo: occupancy-counted FIFO with registered read data and a drop flag for writes refused while full
module sync_fifo
  import input_link_pkg::*;
#(
  parameter int WIDTH = 36,
  parameter int DEPTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  output logic [WIDTH-1:0] rdata,
  output logic             rvalid,
  output logic             empty,
  output logic             full,
  output logic             drop
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = cnt_w(DEPTH);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rdata_q, rdata_d;
  logic rvalid_q, rvalid_d, empty_q, empty_d, full_q, full_d, rd, wr;
  always_comb begin
    rd = re && !empty_q;
    wr = we && (!full_q || rd);
    drop = we && full_q && !rd;
    cnt_d = cnt_q + CW'(wr) - CW'(rd);
    wp_d = wr ? wp_q + 1'b1 : wp_q;
    rp_d = rd ? rp_q + 1'b1 : rp_q;
    empty_d = cnt_d == '0;
    full_d = cnt_d == CW'(DEPTH);
    rdata_d = rd ? mem_q[rp_q] : rdata_q;
    rvalid_d = rd;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      wp_q <= '0;
      rp_q <= '0;
      cnt_q <= '0;
      rdata_q <= '0;
      rvalid_q <= 1'b0;
      empty_q <= 1'b1;
      full_q <= 1'b0;
    end else begin
      wp_q <= wp_d;
      rp_q <= rp_d;
      cnt_q <= cnt_d;
      rdata_q <= rdata_d;
      rvalid_q <= rvalid_d;
      empty_q <= empty_d;
      full_q <= full_d;
    end
  end
  always_ff @(posedge clk) begin
    if (wr) mem_q[wp_q] <= wdata;
  end
  assign rdata = rdata_q;
  assign rvalid = rvalid_q;
  assign empty = empty_q;
  assign full = full_q;
endmodule

// File: rtl/input_link_buffer.sv
// input_link_buffer: packs channel MSBs into one word and buffers it within a start/done event window
module input_link_buffer
  import input_link_pkg::*;
#(
  parameter int NCH        = 2,
  parameter int IN_W       = 32,
  parameter int KEEP       = 18,
  parameter int DEPTH      = 64,
  parameter int EVT_CYCLES = 64,
  parameter int OVF_W      = 16
) (
  input logic clk,
  input logic reset,
  input_link_buffer_if.slave bus
);
  localparam int PW = NCH * KEEP;
  localparam int WCW = ($clog2(EVT_CYCLES) > 0) ? $clog2(EVT_CYCLES) : 1;
  state_t state_q, state_d;
  logic [WCW-1:0] win_q, win_d;
  logic [OVF_W-1:0] ovf_q, ovf_d;
  logic done_q, done_d, we, drop, f_empty;
  logic [PACK_MAX-1:0] pk;
  logic [PW-1:0] packed_w;
  logic unused_pk;
  assign pk = pack_word(PACK_MAX'(bus.data_in), NCH, IN_W, KEEP);
  assign packed_w = pk[PW-1:0];
  assign unused_pk = ^pk[PACK_MAX-1:PW];
  always_comb begin
    state_d = state_q;
    win_d = win_q;
    done_d = 1'b0;
    we = 1'b0;
    case (state_q)
      IDLE: if (bus.start && bus.en_proc) begin
        state_d = ACCEPT;
        win_d = WCW'(EVT_CYCLES - 1);
      end
      ACCEPT: begin
        we = bus.in_valid && bus.en_proc;
        if (bus.en_proc) begin
          if (win_q == '0) state_d = DRAIN;
          else win_d = win_q - 1'b1;
        end
      end
      DRAIN: if (f_empty) begin
        state_d = IDLE;
        done_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    ovf_d = (drop && ovf_q != '1) ? ovf_q + 1'b1 : ovf_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      win_q <= '0;
      done_q <= 1'b0;
      ovf_q <= '0;
    end else begin
      state_q <= state_d;
      win_q <= win_d;
      done_q <= done_d;
      ovf_q <= ovf_d;
    end
  end
  sync_fifo #(.WIDTH(PW), .DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .reset(reset),
    .we(we),
    .wdata(packed_w),
    .re(bus.read_en),
    .rdata(bus.data_out),
    .rvalid(bus.out_valid),
    .empty(f_empty),
    .full(bus.full),
    .drop(drop)
  );
  assign bus.empty = f_empty;
  assign bus.done = done_q;
  assign bus.ovf_count = ovf_q;
endmodule

// File: tb/tb_input_link_buffer.sv
// tb_input_link_buffer: directed table and sequence checks on two buffer configurations
module tb_input_link_buffer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0, en_proc = 1'b0, in_valid = 1'b0, read_en = 1'b0;
  logic [63:0] din = '0;
  int n_chk = 0;
  int n_fail = 0;
  always #5 clk = ~clk;

  input_link_buffer_if #(.OVF_W(16)) ifa ();
  input_link_buffer_if #(.OVF_W(2)) ifb ();
  assign {ifa.start, ifa.en_proc, ifa.in_valid, ifa.read_en, ifa.data_in} = {start, en_proc, in_valid, read_en, din};
  assign {ifb.start, ifb.en_proc, ifb.in_valid, ifb.read_en, ifb.data_in} = {start, en_proc, in_valid, read_en, din};

  input_link_buffer #(.DEPTH(4), .EVT_CYCLES(4)) dut_a (.clk(clk), .reset(rst), .bus(ifa.slave));
  input_link_buffer #(.DEPTH(4), .OVF_W(2)) dut_b (.clk(clk), .reset(rst), .bus(ifb.slave));

  typedef struct {
    logic st, en, iv, re;
    logic [63:0] din;
    logic e_empty, e_full, e_ov, e_done;
    logic [35:0] e_dout;
  } vec_t;
  vec_t tv[13];

  localparam logic [63:0] D1 = 64'hFFFFC000_00004000;
  localparam logic [35:0] P1 = 36'hFFFFC0001;

  function automatic vec_t mk(logic st, logic en, logic iv, logic re, logic [63:0] d,
                              logic ee, logic ef, logic eo, logic ed, logic [35:0] dq);
    vec_t v;
    v.st = st; v.en = en; v.iv = iv; v.re = re; v.din = d;
    v.e_empty = ee; v.e_full = ef; v.e_ov = eo; v.e_done = ed; v.e_dout = dq;
    return v;
  endfunction

  function automatic logic [63:0] wd(int i);
    return {18'(18'h2A000 + i), 14'h3FFF, 18'(18'h00500 + i), 14'h2AAA};
  endfunction

  function automatic logic [35:0] ex(int i);
    return {18'(18'h2A000 + i), 18'(18'h00500 + i)};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_a(input string tag, input logic ee, ef, eo, ed, input logic [35:0] dq, input logic [15:0] ov);
    chk({tag, " a.empty"}, 64'(ifa.empty), 64'(ee));
    chk({tag, " a.full"}, 64'(ifa.full), 64'(ef));
    chk({tag, " a.out_valid"}, 64'(ifa.out_valid), 64'(eo));
    chk({tag, " a.done"}, 64'(ifa.done), 64'(ed));
    chk({tag, " a.data_out"}, 64'(ifa.data_out), 64'(dq));
    chk({tag, " a.ovf_count"}, 64'(ifa.ovf_count), 64'(ov));
  endtask

  task automatic chk_b(input string tag, input logic ee, ef, eo, ed, input logic [35:0] dq, input logic [1:0] ov);
    chk({tag, " b.empty"}, 64'(ifb.empty), 64'(ee));
    chk({tag, " b.full"}, 64'(ifb.full), 64'(ef));
    chk({tag, " b.out_valid"}, 64'(ifb.out_valid), 64'(eo));
    chk({tag, " b.done"}, 64'(ifb.done), 64'(ed));
    chk({tag, " b.data_out"}, 64'(ifb.data_out), 64'(dq));
    chk({tag, " b.ovf_count"}, 64'(ifb.ovf_count), 64'(ov));
  endtask

  task automatic cyc(input logic st, en, iv, re, input logic [63:0] d);
    start = st; en_proc = en; in_valid = iv; read_en = re; din = d;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc(0, 0, 0, 0, '0);
    cyc(0, 0, 0, 0, '0);
    rst = 1'b0;
  endtask

  initial begin
    tv[0]  = mk(0, 0, 0, 1, '0, 1, 0, 0, 0, '0);
    tv[1]  = mk(1, 1, 0, 0, '0, 1, 0, 0, 0, '0);
    tv[2]  = mk(0, 1, 1, 0, D1, 0, 0, 0, 0, '0);
    tv[3]  = mk(0, 1, 1, 0, D1, 0, 0, 0, 0, '0);
    tv[4]  = mk(0, 1, 1, 0, D1, 0, 0, 0, 0, '0);
    tv[5]  = mk(0, 1, 0, 0, '0, 0, 0, 0, 0, '0);
    tv[6]  = mk(0, 1, 0, 1, '0, 0, 0, 1, 0, P1);
    tv[7]  = mk(0, 1, 0, 0, '0, 0, 0, 0, 0, P1);
    tv[8]  = mk(0, 1, 0, 1, '0, 0, 0, 1, 0, P1);
    tv[9]  = mk(0, 1, 0, 1, '0, 1, 0, 1, 0, P1);
    tv[10] = mk(0, 1, 0, 0, '0, 1, 0, 0, 1, P1);
    tv[11] = mk(1, 1, 0, 0, '0, 1, 0, 0, 0, P1);
    tv[12] = mk(0, 1, 1, 0, D1, 0, 0, 0, 0, P1);

    do_reset();
    chk_a("reset", 1, 0, 0, 0, '0, '0);
    chk_b("reset", 1, 0, 0, 0, '0, '0);

    for (int i = 0; i < 13; i++) begin
      cyc(tv[i].st, tv[i].en, tv[i].iv, tv[i].re, tv[i].din);
      chk_a($sformatf("vec%0d", i), tv[i].e_empty, tv[i].e_full, tv[i].e_ov, tv[i].e_done, tv[i].e_dout, '0);
    end

    // Window of 4 with in_valid held: exactly 4 words, no writes once draining
    do_reset();
    cyc(1, 1, 0, 0, '0);
    for (int i = 0; i < 4; i++) begin
      cyc(0, 1, 1, 0, wd(i));
      chk_a($sformatf("win_wr%0d", i), 0, i == 3, 0, 0, '0, '0);
    end
    for (int i = 0; i < 2; i++) begin
      cyc(0, 1, 1, 0, wd(9));
      chk_a($sformatf("drain_iv%0d", i), 0, 1, 0, 0, '0, '0);
    end
    for (int i = 0; i < 4; i++) begin
      cyc(0, 1, 0, 1, '0);
      chk_a($sformatf("win_rd%0d", i), i == 3, 0, 1, 0, ex(i), '0);
    end
    cyc(0, 1, 0, 0, '0);
    chk_a("win_done", 1, 0, 0, 1, ex(3), '0);
    cyc(0, 1, 0, 0, '0);
    chk_a("win_done_end", 1, 0, 0, 0, ex(3), '0);

    // en_proc gap freezes the window; start inside the window is ignored
    do_reset();
    cyc(1, 1, 0, 0, '0);
    cyc(0, 1, 1, 0, wd(0));
    cyc(0, 1, 1, 0, wd(1));
    chk_a("gap_pre", 0, 0, 0, 0, '0, '0);
    for (int i = 0; i < 3; i++) begin
      cyc(1, 0, 1, 0, wd(7));
      chk_a($sformatf("gap_low%0d", i), 0, 0, 0, 0, '0, '0);
    end
    cyc(1, 1, 1, 0, wd(2));
    chk_a("gap_wr2", 0, 0, 0, 0, '0, '0);
    cyc(0, 1, 1, 0, wd(3));
    chk_a("gap_wr3", 0, 1, 0, 0, '0, '0);
    cyc(0, 1, 1, 0, wd(5));
    chk_a("gap_drain", 0, 1, 0, 0, '0, '0);
    for (int i = 0; i < 4; i++) begin
      cyc(0, 0, 0, 1, '0);
      chk_a($sformatf("gap_rd%0d", i), i == 3, 0, 1, 0, ex(i), '0);
    end
    cyc(0, 0, 0, 0, '0);
    chk_a("gap_done", 1, 0, 0, 1, ex(3), '0);
    cyc(0, 0, 0, 0, '0);
    chk_a("gap_done_end", 1, 0, 0, 0, ex(3), '0);

    // Overflow with saturation, read+write while full, read+write while empty
    do_reset();
    cyc(1, 1, 0, 0, '0);
    chk_b("ovf_start", 1, 0, 0, 0, '0, '0);
    for (int i = 0; i < 8; i++) begin
      cyc(0, 1, 1, 0, wd(i));
      chk_b($sformatf("ovf_wr%0d", i), 0, i >= 3, 0, 0, '0, 2'((i < 4) ? 0 : ((i > 6) ? 3 : i - 3)));
    end
    cyc(0, 1, 1, 1, wd(8));
    chk_b("full_rw", 0, 1, 1, 0, ex(0), 2'd3);
    begin
      int ord[4] = '{1, 2, 3, 8};
      for (int k = 0; k < 4; k++) begin
        cyc(0, 1, 0, 1, '0);
        chk_b($sformatf("ovf_rd%0d", k), k == 3, 0, 1, 0, ex(ord[k]), 2'd3);
      end
    end
    cyc(0, 1, 0, 1, '0);
    chk_b("rd_empty", 1, 0, 0, 0, ex(8), 2'd3);
    cyc(0, 1, 1, 1, wd(10));
    chk_b("empty_rw", 0, 0, 0, 0, ex(8), 2'd3);
    cyc(0, 1, 0, 1, '0);
    chk_b("empty_rw_rd", 1, 0, 1, 0, ex(10), 2'd3);

    // Reset in the middle of a window with two words stored
    do_reset();
    cyc(1, 1, 0, 0, '0);
    cyc(0, 1, 1, 0, wd(0));
    cyc(0, 1, 1, 0, wd(1));
    chk_a("mid_pre", 0, 0, 0, 0, '0, '0);
    rst = 1'b1;
    cyc(0, 0, 0, 0, '0);
    rst = 1'b0;
    chk_a("mid_rst", 1, 0, 0, 0, '0, '0);
    for (int i = 0; i < 2; i++) begin
      cyc(0, 1, 1, 0, wd(4));
      chk_a($sformatf("mid_idle%0d", i), 1, 0, 0, 0, '0, '0);
    end
    cyc(0, 1, 0, 1, '0);
    chk_a("mid_rd", 1, 0, 0, 0, '0, '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
